shifter_operand_pipe: RTL and testbench
=======================================

Name: shifter_operand_pipe

Overview:
- Parametrised, two-stage pipelined generator for the data-processing shifter operand and shifter carry-out.
- Supersedes the combinational operand select. Adds a full barrel shifter (LSL/LSR/ASR/ROR/RRX), immediate rotation, carry-out, a valid/ready handshake and flush.
- Sits between decode/register-read and the ALU operand-B input.

Parameters:
- DATA_W, 32, operand width; power of two, >= 8; AW = clog2(DATA_W).
- IMM_W, 8, immediate field width (zero-extended, IMM_W <= DATA_W).
- RS_AMT_W, 8, number of low bits of rs used as a register shift amount (> AW).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- sel  input  2  00 ROTATE_IMM, 01 SHIFT_IMM, 10 RS, 11 reserved.
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- imm  input  IMM_W  immediate value.
- rotate_imm  input  4  rotate field; rotation = 2*rotate_imm mod DATA_W.
- shift_imm  input  AW  immediate shift amount.
- rs  input  DATA_W  shift-amount register.
- rm  input  DATA_W  operand register.
- carry_in  input  1  current C flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- shifter_operand  output  DATA_W  result.
- carry_out  output  1  shifter carry-out.
- out_err  output  1  result came from reserved sel=11.

Behaviour:

Reset (asynchronous, immediate):
- out_valid=0, shifter_operand=0, carry_out=0, out_err=0, internal stage-1 valid=0.
- in_ready=1 after reset deasserts.

Pipeline:
- Stage 1 registers the request fields and resolves the effective amount, either shift_imm or rs[RS_AMT_W-1:0].
- Stage 2 registers the shift/rotate result.
- Latency: accepted at edge N, out_valid at edge N+2. Throughput: 1 per cycle when out_ready=1.
- A stage advances when it is empty or the next stage advances.
- in_ready = !flush && (!s1_valid || s2 advancing), where s2 advances when !out_valid || out_ready.
- While out_valid && !out_ready: shifter_operand, carry_out and out_err hold stable.

Flush:
- flush=1 clears both valid bits at the next edge.
- A request presented in the same cycle is not accepted (in_ready=0).
- Flush beats a simultaneous out_ready handshake; the consumer must not count that beat.

Arithmetic (W=DATA_W, n=amount):
- ROTATE_IMM: result = zero-extended imm rotated right by 2*rotate_imm mod W. Carry = carry_in if the rotation is 0, else result[W-1].
- SHIFT_IMM, LSL: n=0 gives rm with carry_in; otherwise rm<<n with carry rm[W-n].
- SHIFT_IMM, LSR: n=0 means a shift by W, giving 0 with carry rm[W-1]; otherwise rm>>n with carry rm[n-1].
- SHIFT_IMM, ASR: n=0 means a shift by W, giving replicated rm[W-1] with carry rm[W-1]; otherwise an arithmetic shift with carry rm[n-1].
- SHIFT_IMM, ROR: n=0 means RRX, giving {carry_in, rm[W-1:1]} with carry rm[0]; otherwise rotate right by n with carry rm[n-1].
- RS: n=0 gives rm with carry_in for every shift_type.
- RS, LSL: n<W gives rm<<n with carry rm[W-n]; n=W gives 0 with carry rm[0]; n>W gives 0 with carry 0.
- RS, LSR: n<W gives rm>>n with carry rm[n-1]; n=W gives 0 with carry rm[W-1]; n>W gives 0 with carry 0.
- RS, ASR: n<W gives an arithmetic shift with carry rm[n-1]; n>=W gives replicated rm[W-1] with carry rm[W-1].
- RS, ROR: let k=n[AW-1:0]. If k=0 (n!=0), result is rm with carry rm[W-1]; otherwise rotate right by k with carry rm[k-1].
- sel=11: result 0, carry carry_in, out_err=1. It is otherwise a normal beat.

General rules:
- All shifts are width-exact; no X propagation for any amount up to 2^RS_AMT_W-1.
- Reset mid-operation discards all in-flight beats. No partial output.

Test Plan:
- ROTATE_IMM, imm=0xFF, rotate_imm=4, carry_in=0 -> shifter_operand=0xFF000000, carry_out=1, out_valid exactly 2 cycles after acceptance.
- SHIFT_IMM: LSR shift_imm=0 with rm=0x80000001 -> 0x00000000, carry 1. ROR shift_imm=0 (RRX) with rm=0x00000003, carry_in=1 -> 0x80000001, carry 1.
- RS LSL sweep, rm=0x80000001, rs = 0, 1, 31, 32, 33, 0x1FF (low byte 0xFF):
  - rs=0 -> 0x80000001, carry_in.
  - rs=1 -> 0x00000002, carry 1.
  - rs=31 -> 0x80000000, carry 0.
  - rs=32 -> 0, carry 1.
  - rs=33 -> 0, carry 0.
  - rs=0x1FF -> 0, carry 0.
- RS ROR, rs=32, rm=0x80000000 -> 0x80000000, carry 1. RS ASR, rs=40, rm=0x80000000 -> 0xFFFFFFFF, carry 1.
- Back-pressure: 4 back-to-back beats with out_ready held low from cycle 3 for 5 cycles -> in_ready drops once both stages are full; output holds stable; all 4 results emerge in order with none lost or duplicated.
- Flush with 2 beats in flight plus in_valid=1 -> out_valid=0 next cycle and the presented beat is not accepted. Assert reset mid-stream -> outputs zero immediately, in_ready=1 after release.

Source files
------------

// File: rtl/shifter_operand_pipe_if.sv
// Request/response bundle for the shifter-operand pipeline.
// Handshake: a beat moves on a rising edge where valid && ready; the sender holds valid and payload
// steady until then, and ready never looks at valid from the same side.
interface shifter_operand_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 8
);
  localparam int AW = $clog2(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sel;
  logic [1:0]        shift_type;
  logic [IMM_W-1:0]  imm;
  logic [3:0]        rotate_imm;
  logic [AW-1:0]     shift_imm;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rm;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] shifter_operand;
  logic              carry_out;
  logic              out_err;

  modport master (
    output in_valid, sel, shift_type, imm, rotate_imm, shift_imm, rs, rm, carry_in, out_ready,
    input  in_ready, out_valid, shifter_operand, carry_out, out_err
  );

  modport slave (
    input  in_valid, sel, shift_type, imm, rotate_imm, shift_imm, rs, rm, carry_in, out_ready,
    output in_ready, out_valid, shifter_operand, carry_out, out_err
  );
endinterface

// File: rtl/shifter_operand_pipe.sv
// Two-stage shifter-operand generator: stage 1 normalises the request into (operand, amount, type),
// stage 2 runs the barrel shifter and registers result, carry and error flag.
module shifter_operand_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 8,
  parameter int RS_AMT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  shifter_operand_pipe_if.slave p
);
  localparam int AW = $clog2(DATA_W);
  localparam logic [1:0] SEL_ROT = 2'b00, SEL_IMM = 2'b01, SEL_RES = 2'b11;
  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_op;
  logic [RS_AMT_W-1:0] s1_amt;
  logic [1:0]          s1_type;
  logic                s1_rrx, s1_err, s1_cin;

  logic                out_valid_q, carry_q, err_q;
  logic [DATA_W-1:0]   operand_q;

  logic                s2_adv;
  assign s2_adv     = !out_valid_q || p.out_ready;
  assign p.in_ready = !flush && (!s1_valid || s2_adv);

  // Immediate rotation is folded into a ROR of the zero-extended immediate, and the
  // shift_imm==0 encodings of LSR/ASR become an explicit shift by DATA_W.
  logic [DATA_W-1:0]   op_d;
  logic [RS_AMT_W-1:0] amt_d;
  logic [1:0]          type_d;
  logic                rrx_d, err_d;
  logic [AW-1:0]       rot_amt;
  always_comb begin
    rot_amt = AW'({p.rotate_imm, 1'b0});
    op_d    = p.rm;
    amt_d   = p.rs[RS_AMT_W-1:0];
    type_d  = p.shift_type;
    rrx_d   = 1'b0;
    err_d   = 1'b0;
    case (p.sel)
      SEL_ROT: begin
        op_d   = DATA_W'(p.imm);
        amt_d  = RS_AMT_W'(rot_amt);
        type_d = ROR;
      end
      SEL_IMM: begin
        amt_d = RS_AMT_W'(p.shift_imm);
        if (p.shift_imm == '0) begin
          if (p.shift_type == LSR || p.shift_type == ASR) amt_d = RS_AMT_W'(DATA_W);
          if (p.shift_type == ROR) rrx_d = 1'b1;
        end
      end
      SEL_RES: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_amt   <= '0;
      s1_type  <= '0;
      s1_rrx   <= 1'b0;
      s1_err   <= 1'b0;
      s1_cin   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!s1_valid || s2_adv) begin
      s1_valid <= p.in_valid;
      if (p.in_valid) begin
        s1_op   <= op_d;
        s1_amt  <= amt_d;
        s1_type <= type_d;
        s1_rrx  <= rrx_d;
        s1_err  <= err_d;
        s1_cin  <= p.carry_in;
      end
    end
  end

  // Shifting through a one-bit extension yields result and carry together for every amount,
  // including amounts at or beyond DATA_W.
  logic [DATA_W-1:0]   res_d;
  logic                carry_d;
  logic [2*DATA_W-1:0] rot_dbl;
  logic signed [DATA_W:0] asr_src, asr_res;
  always_comb begin
    res_d   = s1_op;
    carry_d = s1_cin;
    rot_dbl = {s1_op, s1_op} >> s1_amt[AW-1:0];
    asr_src = {s1_op, 1'b0};
    asr_res = asr_src >>> s1_amt;
    if (s1_err) begin
      res_d = '0;
    end else if (s1_rrx) begin
      res_d   = {s1_cin, s1_op[DATA_W-1:1]};
      carry_d = s1_op[0];
    end else if (s1_amt != '0) begin
      case (s1_type)
        LSL:     {carry_d, res_d} = {1'b0, s1_op} << s1_amt;
        LSR:     {res_d, carry_d} = {s1_op, 1'b0} >> s1_amt;
        ASR:     {res_d, carry_d} = asr_res;
        default: begin
          res_d   = rot_dbl[DATA_W-1:0];
          carry_d = rot_dbl[DATA_W-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      operand_q   <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        operand_q <= res_d;
        carry_q   <= carry_d;
        err_q     <= s1_err;
      end
    end
  end

  assign p.out_valid       = out_valid_q;
  assign p.shifter_operand = operand_q;
  assign p.carry_out       = carry_q;
  assign p.out_err         = err_q;

  generate
    if (RS_AMT_W < DATA_W) begin : g_rs_hi
      logic unused_rs_hi;
      assign unused_rs_hi = ^p.rs[DATA_W-1:RS_AMT_W];
    end
  endgenerate
endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Bench for shifter_operand_pipe: directed vectors, a rule-level operand model and an in-flight
// queue that predicts in_ready, out_valid timing and every delivered result.
module tb_shifter_operand_pipe;
  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  stype;
    logic [7:0]  imm;
    logic [3:0]  rot;
    logic [4:0]  shimm;
    logic [31:0] rs;
    logic [31:0] rm;
    logic        cin;
  } vec_t;

  logic clk = 1'b0;
  logic reset, flush;
  logic run = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  vec_t cur;
  logic [33:0] exp_q[$];
  int          acc_q[$];

  shifter_operand_pipe_if #(.DATA_W(32), .IMM_W(8)) bus ();
  shifter_operand_pipe #(.DATA_W(32), .IMM_W(8), .RS_AMT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .p(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
    return r;
  endfunction

  function automatic logic [31:0] sar(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? x[i + n] : x[31];
    return r;
  endfunction

  // Result as {err, carry, operand}, straight from the operand rules.
  function automatic logic [33:0] model(input vec_t v);
    logic [31:0] r;
    logic c, e;
    int n, k;
    e = 1'b0; r = 32'h0; c = v.cin;
    case (v.sel)
      2'd0: begin
        n = (2 * int'(v.rot)) % 32;
        r = rotr({24'h0, v.imm}, n);
        c = (n == 0) ? v.cin : r[31];
      end
      2'd1: begin
        n = int'(v.shimm);
        case (v.stype)
          2'd0: if (n == 0) begin r = v.rm; c = v.cin; end
                else begin r = v.rm << n; c = v.rm[32 - n]; end
          2'd1: if (n == 0) begin r = 32'h0; c = v.rm[31]; end
                else begin r = v.rm >> n; c = v.rm[n - 1]; end
          2'd2: if (n == 0) begin r = {32{v.rm[31]}}; c = v.rm[31]; end
                else begin r = sar(v.rm, n); c = v.rm[n - 1]; end
          default: if (n == 0) begin r = {v.cin, v.rm[31:1]}; c = v.rm[0]; end
                   else begin r = rotr(v.rm, n); c = v.rm[n - 1]; end
        endcase
      end
      2'd2: begin
        n = int'(v.rs[7:0]);
        k = n % 32;
        if (n == 0) begin r = v.rm; c = v.cin; end
        else case (v.stype)
          2'd0: if (n < 32) begin r = v.rm << n; c = v.rm[32 - n]; end
                else if (n == 32) begin r = 32'h0; c = v.rm[0]; end
                else begin r = 32'h0; c = 1'b0; end
          2'd1: if (n < 32) begin r = v.rm >> n; c = v.rm[n - 1]; end
                else if (n == 32) begin r = 32'h0; c = v.rm[31]; end
                else begin r = 32'h0; c = 1'b0; end
          2'd2: if (n < 32) begin r = sar(v.rm, n); c = v.rm[n - 1]; end
                else begin r = {32{v.rm[31]}}; c = v.rm[31]; end
          default: if (k == 0) begin r = v.rm; c = v.rm[31]; end
                   else begin r = rotr(v.rm, k); c = v.rm[k - 1]; end
        endcase
      end
      default: begin e = 1'b1; r = 32'h0; c = v.cin; end
    endcase
    return {e, c, r};
  endfunction

  function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] stype, input logic [7:0] imm,
                              input logic [3:0] rot, input logic [4:0] shimm, input logic [31:0] rs,
                              input logic [31:0] rm, input logic cin);
    vec_t v;
    v.sel = sel; v.stype = stype; v.imm = imm; v.rot = rot; v.shimm = shimm;
    v.rs = rs; v.rm = rm; v.cin = cin;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cur = v;
    bus.sel = v.sel; bus.shift_type = v.stype; bus.imm = v.imm; bus.rotate_imm = v.rot;
    bus.shift_imm = v.shimm; bus.rs = v.rs; bus.rm = v.rm; bus.carry_in = v.cin;
  endtask

  task automatic send(input vec_t v);
    logic acc;
    int t;
    drive(v);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", t);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Per-cycle compare against the in-flight queue; pops on handshake, pushes on acceptance.
  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    cyc++;
    if (reset || !run) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      exp_valid = (exp_q.size() > 0) && (acc_q[0] <= cyc - 2);
      exp_ready = !flush && !(exp_q.size() >= 2 && !bus.out_ready);
      check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      if (exp_valid && bus.out_valid)
        check("result", 64'({bus.out_err, bus.carry_out, bus.shifter_operand}), 64'(exp_q[0]));
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (exp_valid && bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (bus.in_valid && exp_ready) begin
          exp_q.push_back(model(cur));
          acc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t dir[$];
  vec_t bp[4];

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(mk(2'd0, 2'd0, 8'h0, 4'h0, 5'h0, 32'h0, 32'h0, 1'b0));
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_operand", 64'(bus.shifter_operand), 64'd0);
    check("rst_carry", 64'(bus.carry_out), 64'd0);
    check("rst_err", 64'(bus.out_err), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    run = 1'b1;

    // Hand-computed values pinning the model.
    check("pin_rot_imm", 64'(model(mk(2'd0, 2'd0, 8'hFF, 4'd4, 5'd0, 32'h0, 32'h0, 1'b0))), 64'h1_FF00_0000);
    check("pin_lsr0", 64'(model(mk(2'd1, 2'd1, 8'h0, 4'd0, 5'd0, 32'h0, 32'h8000_0001, 1'b0))), 64'h1_0000_0000);
    check("pin_rrx", 64'(model(mk(2'd1, 2'd3, 8'h0, 4'd0, 5'd0, 32'h0, 32'h0000_0003, 1'b1))), 64'h1_8000_0001);
    check("pin_rs_lsl31", 64'(model(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd31, 32'h8000_0001, 1'b1))), 64'h0_8000_0000);
    check("pin_rs_lsl32", 64'(model(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd32, 32'h8000_0001, 1'b0))), 64'h1_0000_0000);
    check("pin_rs_ror32", 64'(model(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'd32, 32'h8000_0000, 1'b0))), 64'h1_8000_0000);
    check("pin_rs_asr40", 64'(model(mk(2'd2, 2'd2, 8'h0, 4'd0, 5'd0, 32'd40, 32'h8000_0000, 1'b0))), 64'h1_FFFF_FFFF);
    check("pin_reserved", 64'(model(mk(2'd3, 2'd0, 8'h0, 4'd0, 5'd0, 32'h0, 32'h1234_5678, 1'b1))), 64'h3_0000_0000);

    // First beat: latency of exactly two edges, literal result.
    send(mk(2'd0, 2'd0, 8'hFF, 4'd4, 5'd0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
    check("lat_edge2_result", 64'({bus.out_err, bus.carry_out, bus.shifter_operand}), 64'h1_FF00_0000);
    drain();

    dir.push_back(mk(2'd1, 2'd1, 8'h0, 4'd0, 5'd0, 32'hFF, 32'h8000_0001, 1'b0));
    dir.push_back(mk(2'd1, 2'd3, 8'h0, 4'd0, 5'd0, 32'hFF, 32'h0000_0003, 1'b1));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd0, 32'h8000_0001, 1'b1));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd1, 32'h8000_0001, 1'b0));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd31, 32'h8000_0001, 1'b1));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd32, 32'h8000_0001, 1'b0));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd33, 32'h8000_0001, 1'b1));
    dir.push_back(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'h1FF, 32'h8000_0001, 1'b1));
    dir.push_back(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'd32, 32'h8000_0000, 1'b0));
    dir.push_back(mk(2'd2, 2'd2, 8'h0, 4'd0, 5'd0, 32'd40, 32'h8000_0000, 1'b0));
    dir.push_back(mk(2'd0, 2'd1, 8'h3F, 4'd0, 5'd0, 32'h0, 32'h0, 1'b1));
    dir.push_back(mk(2'd0, 2'd0, 8'h81, 4'd1, 5'd0, 32'h0, 32'h0, 1'b1));
    dir.push_back(mk(2'd1, 2'd0, 8'h0, 4'd0, 5'd4, 32'hFF, 32'hF000_0001, 1'b0));
    dir.push_back(mk(2'd1, 2'd0, 8'h0, 4'd0, 5'd0, 32'hFF, 32'h1234_5678, 1'b1));
    dir.push_back(mk(2'd1, 2'd2, 8'h0, 4'd0, 5'd4, 32'h0, 32'h8000_0010, 1'b1));
    dir.push_back(mk(2'd1, 2'd2, 8'h0, 4'd0, 5'd0, 32'h0, 32'h8000_0000, 1'b0));
    dir.push_back(mk(2'd1, 2'd3, 8'h0, 4'd0, 5'd8, 32'h0, 32'h1234_5678, 1'b1));
    dir.push_back(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'd32, 32'h8000_0000, 1'b0));
    dir.push_back(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'd40, 32'h8000_0000, 1'b1));
    dir.push_back(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'd4, 32'h0000_001F, 1'b0));
    dir.push_back(mk(2'd2, 2'd2, 8'h0, 4'd0, 5'd0, 32'd5, 32'h7FFF_FFF0, 1'b0));
    dir.push_back(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'd36, 32'h0000_000F, 1'b0));
    dir.push_back(mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'h100, 32'hCAFE_F00D, 1'b0));
    dir.push_back(mk(2'd3, 2'd2, 8'h5A, 4'd3, 5'd7, 32'd7, 32'hDEAD_BEEF, 1'b1));
    foreach (dir[i]) send(dir[i]);
    drain();

    // Back-pressure: four beats back to back, consumer stalls from the third cycle for five.
    bp[0] = mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd3, 32'h0000_0011, 1'b0);
    bp[1] = mk(2'd1, 2'd1, 8'h0, 4'd0, 5'd2, 32'h0, 32'hF000_000F, 1'b0);
    bp[2] = mk(2'd0, 2'd0, 8'hA5, 4'd2, 5'd0, 32'h0, 32'h0, 1'b0);
    bp[3] = mk(2'd2, 2'd3, 8'h0, 4'd0, 5'd0, 32'd12, 32'h1234_5678, 1'b0);
    fork
      begin
        foreach (bp[i]) send(bp[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two beats in flight and a third presented in the same cycle.
    send(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd8, 32'h0000_00FF, 1'b0));
    send(mk(2'd2, 2'd1, 8'h0, 4'd0, 5'd0, 32'd8, 32'hFF00_0000, 1'b0));
    drive(mk(2'd0, 2'd0, 8'h77, 4'd0, 5'd0, 32'h0, 32'h0, 1'b0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_dropped", 64'(bus.out_valid), 64'd0);
    send(mk(2'd1, 2'd3, 8'h0, 4'd0, 5'd16, 32'h0, 32'hAAAA_5555, 1'b0));
    drain();

    // Asynchronous reset with beats in flight.
    send(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd1, 32'h4000_0001, 1'b1));
    send(mk(2'd2, 2'd0, 8'h0, 4'd0, 5'd0, 32'd2, 32'h4000_0001, 1'b1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_operand", 64'(bus.shifter_operand), 64'd0);
    check("mid_rst_carry", 64'(bus.carry_out), 64'd0);
    check("mid_rst_err", 64'(bus.out_err), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_output", 64'(bus.out_valid), 64'd0);
    send(mk(2'd1, 2'd2, 8'h0, 4'd0, 5'd31, 32'h0, 32'h8000_0000, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
